// File: rtl/inst_ram_loader_pkg.sv
// inst_ram_loader_pkg
//   Shared constants and types for the instruction RAM loader slice:
//   loader FSM state encoding, array geometry (256 bytes, 8-bit address,
//   32-bit words) and big-endian byte lane indices.
//   Optional feature macro used by the slice: LOADER_VERIFY_EN.
package inst_ram_loader_pkg;

  localparam int MEM_DEPTH  = 256;
  localparam int AW         = 8;
  localparam int WW         = 32;
  localparam int BYTE_LANES = 4;

  // Lane 0 is the most significant byte; it lands at the lowest address.
  localparam logic [1:0] LANE_MSB = 2'd0;
  localparam logic [1:0] LANE_LSB = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WRITE,
    ST_VERIFY,
    ST_DONE
  } state_t;

  // Byte of a word for a given big-endian lane.
  function automatic logic [7:0] word_byte(logic [WW-1:0] w, logic [1:0] lane);
    logic [1:0] sh;
    sh = LANE_LSB - lane;
    return w[{sh, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/inst_ram_loader_if.sv
// inst_ram_loader_if
//   Host -> loader write channel.
//   Start/BaseAddr open a session; WrData/WrValid/WrLast with WrReady form
//   the valid/ready word handshake.
//   master : host/boot source (drives Start, BaseAddr, WrData, WrValid, WrLast)
//   slave  : loader (drives WrReady)
interface inst_ram_loader_if;
  import inst_ram_loader_pkg::*;

  logic          Start;
  logic [AW-1:0] BaseAddr;
  logic [WW-1:0] WrData;
  logic          WrValid;
  logic          WrLast;
  logic          WrReady;

  modport master (output Start, BaseAddr, WrData, WrValid, WrLast, input WrReady);
  modport slave  (input Start, BaseAddr, WrData, WrValid, WrLast, output WrReady);
endinterface

// File: rtl/inst_ram_loader_ram256x8_dp.sv
// ram256x8_dp
//   Byte array with one synchronous byte write port and a combinational
//   fetch read port. Aligned fetch addresses return the big-endian word
//   starting there; unaligned ones return the single byte, zero-extended.
//   With LOADER_VERIFY_EN a second combinational word port serves readback.
//   Ports: CLK, we/waddr/wdata (write), rd_addr/rd_data (fetch),
//          vf_addr/vf_data (verify, macro only).
//   Contents are not reset.
module ram256x8_dp
  import inst_ram_loader_pkg::*;
#(
  parameter int DEPTH = inst_ram_loader_pkg::MEM_DEPTH
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] rd_addr,
  output logic [WW-1:0] rd_data
`ifdef LOADER_VERIFY_EN
  ,
  input  logic [AW-1:0] vf_addr,
  output logic [WW-1:0] vf_data
`endif
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // Lane l reads address+l; the 8-bit sum wraps 255 -> 0 like the write side.
  logic [BYTE_LANES-1:0][7:0] rd_lane;

  for (genvar l = 0; l < BYTE_LANES; l++) begin : g_rd_lane
    assign rd_lane[l] = mem[rd_addr + AW'(l)];
  end

  assign rd_data = (rd_addr[1:0] == 2'b00) ?
                   {rd_lane[0], rd_lane[1], rd_lane[2], rd_lane[3]} :
                   {24'b0, rd_lane[0]};

`ifdef LOADER_VERIFY_EN
  logic [BYTE_LANES-1:0][7:0] vf_lane;

  for (genvar l = 0; l < BYTE_LANES; l++) begin : g_vf_lane
    assign vf_lane[l] = mem[vf_addr + AW'(l)];
  end

  assign vf_data = {vf_lane[0], vf_lane[1], vf_lane[2], vf_lane[3]};
`endif

endmodule

// File: rtl/inst_ram_loader.sv
// inst_ram_loader
//   Synthesizable load path for the instruction memory. Accepts 32-bit
//   words over a valid/ready handshake and writes them big-endian, one byte
//   per cycle, into a 256x8 array that the fetch stage reads combinationally.
//   Optional macro LOADER_VERIFY_EN: after each word the four bytes are read
//   back and compared; a mismatch sets the sticky Err flag.
//   Ports:
//     CLK, CLR       clock, asynchronous active-high reset
//     bus            write channel (slave side of inst_ram_loader_if)
//     Busy           session in progress
//     Done           session finished (held until next Start)
//     Wrapped        write address rolled 255 -> 0 this session
//     WordCount      words written this session, modulo 128
//     Err            readback mismatch (0 without LOADER_VERIFY_EN)
//     RdAddr/RdData  fetch read port, RdAddr[7:0] used
module inst_ram_loader
  import inst_ram_loader_pkg::*;
#(
  parameter int MEM_DEPTH = inst_ram_loader_pkg::MEM_DEPTH
) (
  input  logic          CLK,
  input  logic          CLR,
  inst_ram_loader_if.slave bus,
  output logic          Busy,
  output logic          Done,
  output logic          Wrapped,
  output logic [6:0]    WordCount,
  output logic          Err,
  input  logic [31:0]   RdAddr,
  output logic [31:0]   RdData
);

  state_t        state, nxt;
  logic [AW-1:0] waddr;
  logic [1:0]    bc;
  logic [WW-1:0] word_q;
  logic          last_q;
  logic [6:0]    wcnt;
  logic          wrapped_q;
  logic          we;
  logic [7:0]    wbyte;

  logic rd_addr_unused;
  assign rd_addr_unused = ^RdAddr[31:AW];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt         = state;
    bus.WrReady = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.Start) nxt = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        bus.WrReady = 1'b1;
        Busy        = 1'b1;
        if (bus.WrValid) nxt = ST_WRITE;
      end
      ST_WRITE: begin
        Busy = 1'b1;
        if (bc == LANE_LSB) begin
`ifdef LOADER_VERIFY_EN
          nxt = ST_VERIFY;
`else
          nxt = last_q ? ST_DONE : ST_ACCEPT;
`endif
        end
      end
`ifdef LOADER_VERIFY_EN
      ST_VERIFY: begin
        Busy = 1'b1;
        nxt  = last_q ? ST_DONE : ST_ACCEPT;
      end
`endif
      ST_DONE: begin
        Done = 1'b1;
        if (bus.Start) nxt = ST_ACCEPT;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      waddr     <= '0;
      bc        <= '0;
      word_q    <= '0;
      last_q    <= 1'b0;
      wcnt      <= '0;
      wrapped_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.Start) begin
            waddr     <= {bus.BaseAddr[AW-1:2], 2'b00};
            wcnt      <= '0;
            wrapped_q <= 1'b0;
          end
        end
        ST_ACCEPT: begin
          if (bus.WrValid) begin
            word_q <= bus.WrData;
            last_q <= bus.WrLast;
            bc     <= LANE_MSB;
          end
        end
        ST_WRITE: begin
          waddr <= waddr + 1'b1;
          bc    <= bc + 1'b1;
          if (waddr == '1)     wrapped_q <= 1'b1;
          if (bc == LANE_LSB)  wcnt      <= wcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign we        = (state == ST_WRITE);
  assign wbyte     = word_byte(word_q, bc);
  assign Wrapped   = wrapped_q;
  assign WordCount = wcnt;

`ifdef LOADER_VERIFY_EN
  logic          err_q;
  logic [AW-1:0] vf_addr;
  logic [WW-1:0] vf_data;

  // In VERIFY waddr has already advanced past the word just written.
  assign vf_addr = waddr - AW'(BYTE_LANES);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      err_q <= 1'b0;
    end else if ((state == ST_IDLE || state == ST_DONE) && bus.Start) begin
      err_q <= 1'b0;
    end else if (state == ST_VERIFY && vf_data != word_q) begin
      err_q <= 1'b1;
    end
  end

  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

  ram256x8_dp #(.DEPTH(MEM_DEPTH)) u_ram (
    .CLK     (CLK),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wbyte),
    .rd_addr (RdAddr[AW-1:0]),
    .rd_data (RdData)
`ifdef LOADER_VERIFY_EN
    ,
    .vf_addr (vf_addr),
    .vf_data (vf_data)
`endif
  );

endmodule
